// File: rtl/speed_actuator_if.sv
// Driver/actuator bundle for speed_actuator: control requests in, speed and door status out.
interface speed_actuator_if;
  logic       accelerate_car;
  logic       unlock_doors;
  logic [7:0] speed_limit;
  logic [7:0] car_speed;
  logic       doors_unlocked;
  logic       moving;

  modport master (
    output accelerate_car, unlock_doors, speed_limit,
    input  car_speed, doors_unlocked, moving
  );

  modport slave (
    input  accelerate_car, unlock_doors, speed_limit,
    output car_speed, doors_unlocked, moving
  );
endinterface

// File: rtl/speed_actuator.sv
// Speed actuator: ramps car_speed toward min(speed_limit, MAX_SPEED) in STEP increments per tick.
// Define HARD_BRAKE_EN to brake by 2*STEP while the car is above its target.
module speed_actuator #(
  parameter logic [7:0]  STEP      = 8'd5,
  parameter int unsigned TICK_DIV  = 4,
  parameter logic [7:0]  MAX_SPEED = 8'd200
) (
  input  logic              clk,
  input  logic              rst,
  speed_actuator_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, BRAKE} state_t;

  localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

  state_t     state;
  logic [7:0] speed_q;
  logic [7:0] cnt;
  logic       doors_q;

  logic [7:0] target;
  logic       tick;
  logic [8:0] inc_sum;
  logic [7:0] accel_val;
  logic [8:0] brake_dec;
  logic [7:0] brake_val;
  logic [7:0] brake_next;

  always_comb begin
    target    = (bus.speed_limit < MAX_SPEED) ? bus.speed_limit : MAX_SPEED;
    tick      = (cnt == TICK_LAST);
    inc_sum   = {1'b0, speed_q} + {1'b0, STEP};
    accel_val = (inc_sum >= {1'b0, target}) ? target : inc_sum[7:0];
`ifdef HARD_BRAKE_EN
    brake_dec = (speed_q > target) ? {STEP, 1'b0} : {1'b0, STEP};
`else
    brake_dec = {1'b0, STEP};
`endif
    // Saturate at zero; the guard keeps brake_dec below 256 whenever it is subtracted.
    brake_val  = ({1'b0, speed_q} > brake_dec) ? (speed_q - brake_dec[7:0]) : '0;
    brake_next = tick ? brake_val : speed_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      speed_q <= '0;
      cnt     <= '0;
      doors_q <= 1'b0;
    end else begin
      doors_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          doors_q <= bus.unlock_doors && (speed_q == '0);
          if (bus.accelerate_car && !bus.unlock_doors && (target != '0))
            state <= ACCEL;
        end

        ACCEL: begin
          // Braking requests win over a pending tick.
          if (!bus.accelerate_car || (target < speed_q)) begin
            state <= BRAKE;
            cnt   <= '0;
          end else if (tick) begin
            speed_q <= accel_val;
            cnt     <= '0;
            if (accel_val == target)
              state <= CRUISE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        CRUISE: begin
          cnt <= '0;
          if (!bus.accelerate_car || (target < speed_q))
            state <= BRAKE;
          else if (target > speed_q)
            state <= ACCEL;
        end

        BRAKE: begin
          speed_q <= brake_next;
          cnt     <= tick ? '0 : (cnt + 8'd1);
          if (brake_next == '0) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (bus.accelerate_car && (brake_next < target)) begin
            state <= ACCEL;
            cnt   <= '0;
          end else if (bus.accelerate_car && (brake_next == target)) begin
            state <= CRUISE;
            cnt   <= '0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.car_speed      = speed_q;
  assign bus.doors_unlocked = doors_q;
  assign bus.moving         = (speed_q != '0);

endmodule
